// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor/adder slice.
package serial_sub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/serial_fs_cell.sv
// Combinational 1-bit full subtractor (op=OP_SUB) or full adder (op=OP_ADD).
module serial_fs_cell
  import serial_sub_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  logic bin,
  input  logic op,
  output logic res_bit,
  output logic bout
);

  // Sum and difference bits are identical; only borrow vs carry differs.
  assign res_bit = a_bit ^ b_bit ^ bin;
  assign bout    = (op == OP_ADD)
                 ? ((a_bit & b_bit) | (bin & (a_bit ^ b_bit)))
                 : ((~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b (LSB first) with valid/ready ports; result {borrow, diff}.
// Define SERIAL_SUBTRACTOR_ADD_EN to add the op port (op=1 selects a+b).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    count;
  logic             bor;
  logic             bor_next;
  logic             res_bit;
  logic             op_r;
  logic [WIDTH:0]   res_shift;

`ifndef SERIAL_SUBTRACTOR_ADD_EN
  assign op_r = OP_SUB;
`endif

  serial_fs_cell u_cell (
    .a_bit   (a_sr[0]),
    .b_bit   (b_sr[0]),
    .bin     (bor),
    .op      (op_r),
    .res_bit (res_bit),
    .bout    (bor_next)
  );

  // New bit enters at the MSB; written this way so WIDTH=1 stays legal.
  always_comb begin
    res_shift = {res_bit, res_sr};
    res_next  = res_shift[WIDTH:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      d         <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      bor       <= 1'b0;
      count     <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      op_r      <= OP_SUB;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            bor      <= 1'b0;
            count    <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
            op_r     <= op;
`endif
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          bor    <= bor_next;
          count  <= count + CW'(1);
          if (count == LAST) begin
            d         <= {bor_next, res_next};
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   d;
  logic         busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef SERIAL_SUBTRACTOR_ADD_EN
  localparam bit HAS_ADD = 1'b1;
`else
  localparam bit HAS_ADD = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer result truncated to W+1 bits (two's complement).
  function automatic logic [W:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic o);
    int r;
    r = o ? (int'(x) + int'(y)) : (int'(x) - int'(y));
    return r[W:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; random a/b/in_valid noise during RUN and DONE.
  task automatic do_req(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xo,
                        input int unsigned hold);
    logic [W:0]  exp;
    logic [W:0]  first_d;
    int unsigned cyc;
    exp = ref_d(xa, xb, xo);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    a = xa; b = xb; op = xo; in_valid = 1'b1;
    tick();
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      a = W'($urandom); b = W'($urandom); op = HAS_ADD & $urandom_range(0, 1);
      in_valid = $urandom_range(0, 1);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, W);
    check("result", 32'(d), 32'(exp));
    first_d = d;
    for (int i = 0; i < int'(hold); i++) begin
      in_valid = $urandom_range(0, 1); a = W'($urandom); b = W'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_d", 32'(d), 32'(first_d));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("consumed_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
    check("idle_d_kept", 32'(d), 32'(first_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_d", 32'(d), 32'd0);

    do_req(4'd3, 4'd2, 1'b0, 0);
    check("dir_3_2", 32'(d), 32'h01);
    do_req(4'd1, 4'd8, 1'b0, 0);
    check("dir_1_8", 32'(d), 32'h19);
    do_req(4'd12, 4'd14, 1'b0, 0);
    check("dir_12_14", 32'(d), 32'h1E);
    do_req(4'd3, 4'd11, 1'b0, 0);
    check("dir_3_11", 32'(d), 32'h18);
    do_req(4'd0, 4'd0, 1'b0, 0);
    check("dir_0_0", 32'(d), 32'h00);
    do_req(4'd15, 4'd0, 1'b0, 5);
    check("dir_15_0", 32'(d), 32'h0F);
    do_req(4'd0, 4'd15, 1'b0, 1);
    check("dir_0_15", 32'(d), 32'h11);

    // Abort during the second RUN cycle.
    out_ready = 1'b1;
    a = 4'd9; b = 4'd4; op = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_req(4'd9, 4'd4, 1'b0, 0);
    check("dir_9_4", 32'(d), 32'h05);

    if (HAS_ADD) begin
      do_req(4'd12, 4'd14, 1'b1, 0);
      check("add_12_14", 32'(d), 32'h1A);
      do_req(4'd1, 4'd8, 1'b1, 0);
      check("add_1_8", 32'(d), 32'h09);
      do_req(4'd1, 4'd8, 1'b0, 0);
      check("sub_1_8", 32'(d), 32'h19);
    end

    for (int i = 0; i < 30; i++) begin
      do_req(W'($urandom), W'($urandom), HAS_ADD & $urandom_range(0, 1),
             $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
